// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline skid register.
//   - DEF_*_W       default payload field widths
//   - pipe_payload_t payload carried between stages (default widths)
//   - pipe_state_t   occupancy of the two-entry skid register
//   - NOP_INSTR      instruction value presented while no payload is valid
package pipe_pkg;

    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_PC_W      = 32;
    localparam int DEF_ROB_IDX_W = 4;
    localparam int DEF_EXC_W     = 3;

    localparam int unsigned NOP_INSTR = 0;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0]   instruction;
        logic [DEF_PC_W-1:0]      pc;
        logic [DEF_ROB_IDX_W-1:0] complete_idx;
        logic [DEF_EXC_W-1:0]     exception_vector;
    } pipe_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+payload register of the skid buffer.
//   clk    in   clock
//   reset  in   asynchronous active-low reset (clears valid and payload)
//   load   in   capture d and set valid
//   clear  in   drop valid and zero the payload (wins over load)
//   d      in   payload to capture
//   valid  out  entry holds a payload
//   q      out  held payload (zero when cleared)
module pipe_entry
    import pipe_pkg::*;
#(
    parameter type T = pipe_payload_t
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  T     d,
    output logic valid,
    output T     q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready inter-stage register with a two-entry skid buffer.
//   clk, reset               clock and asynchronous active-low reset
//   in_valid / out_in_ready  upstream handshake (ready is registered)
//   in_instruction, in_PC, in_complete_idx, in_exception_vector  upstream payload
//   in_flush                 drop everything held and incoming
//   in_hold                  external stall, blocks the downstream transfer
//   in_ready / out_valid     downstream handshake
//   out_instruction, out_PC, out_complete_idx, out_exception_vector
//                            presented payload, all zero while !out_valid
//   out_stall_cycles         saturating count of cycles with a payload not taken
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int PC_W      = 32,
    parameter int ROB_IDX_W = 4,
    parameter int EXC_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 out_in_ready,
    input  logic [INSTR_W-1:0]   in_instruction,
    input  logic [PC_W-1:0]      in_PC,
    input  logic [ROB_IDX_W-1:0] in_complete_idx,
    input  logic [EXC_W-1:0]     in_exception_vector,
    input  logic                 in_flush,
    input  logic                 in_hold,
    input  logic                 in_ready,
    output logic                 out_valid,
    output logic [INSTR_W-1:0]   out_instruction,
    output logic [PC_W-1:0]      out_PC,
    output logic [ROB_IDX_W-1:0] out_complete_idx,
    output logic [EXC_W-1:0]     out_exception_vector,
    output logic [CNT_W-1:0]     out_stall_cycles
);

    typedef struct packed {
        logic [INSTR_W-1:0]   instruction;
        logic [PC_W-1:0]      pc;
        logic [ROB_IDX_W-1:0] complete_idx;
        logic [EXC_W-1:0]     exception_vector;
    } payload_t;

    pipe_state_t state, next_state;
    payload_t    in_payload, main_d, main_q, skid_q;
    logic        main_valid, skid_valid;
    logic        main_load, main_clear, skid_load, skid_clear;
    logic        ready_q;
    logic        take, acc;
    logic [CNT_W-1:0] stall_cnt;

    assign in_payload = '{instruction:      in_instruction,
                          pc:               in_PC,
                          complete_idx:     in_complete_idx,
                          exception_vector: in_exception_vector};

    assign take = main_valid && in_ready && !in_hold;
    assign acc  = in_valid && ready_q;

    pipe_entry #(.T(payload_t)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_entry #(.T(payload_t)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != ST_FULL);
        end
    end

    // Flush overrides every transition; otherwise main always holds the
    // oldest payload and skid only fills when main cannot drain.
    always_comb begin
        next_state = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_payload;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (in_flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            next_state = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_load  = 1'b1;
                        next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        skid_load  = 1'b1;
                        next_state = ST_FULL;
                    end else if (take) begin
                        main_clear = 1'b1;
                        next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        main_d     = skid_q;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                        next_state = ST_ONE;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !take && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_in_ready         = ready_q;
    assign out_valid            = main_valid;
    assign out_instruction      = main_valid ? main_q.instruction : INSTR_W'(NOP_INSTR);
    assign out_PC               = main_valid ? main_q.pc : '0;
    assign out_complete_idx     = main_valid ? main_q.complete_idx : '0;
    assign out_exception_vector = main_valid ? main_q.exception_vector : '0;
    assign out_stall_cycles     = stall_cnt;

    // The skid entry only ever holds a payload behind a valid main entry.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule
